// File: rtl/game_flow_controller.sv
// Pinball game sequencer: serve/play/lost/over flow, per-frame collision events, lives and BCD score.
// Optional build macro BONUS_LIFE_EN adds an extra life each time the score crosses a multiple of 50.
module game_flow_controller #(
    parameter int LIVES_INIT        = 3,
    parameter int LOST_DELAY_FRAMES = 60,
    parameter int FLIPPER_POINTS    = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       collisionSmileyFlipper,
    input  logic       collisionSmileyBottom,
    input  logic       key5IsPressed,
    output logic       launchBall,
    output logic       freezeBall,
    output logic       gameOver,
    output logic [2:0] lives,
    output logic [7:0] scoreBCD,
    output logic [2:0] state
);

    // state | meaning
    // IDLE  | ball frozen, waiting for key5 to serve
    // SERVE | ball reloaded at start position until next frame
    // PLAY  | ball moving, collisions scored once per frame
    // LOST  | ball frozen for LOST_DELAY_FRAMES frames
    // OVER  | no lives left, key5 restarts the game
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
    localparam logic [7:0] LAST_FRAME = 8'(LOST_DELAY_FRAMES - 1);
    localparam logic [3:0] PTS        = 4'(FLIPPER_POINTS);

    state_t     state_q, state_next;
    logic [2:0] lives_q, lives_next;
    logic [7:0] score_q, score_next;
    logic [7:0] frame_cnt_q, frame_cnt_next;
    logic       key5_d, key5_rise;
    logic       flip_flag, lost_flag, prev_flip;

    logic [4:0] units_sum;
    logic [7:0] score_bin;
    logic       score_sat;
    logic [7:0] score_inc;

    assign key5_rise = key5IsPressed & ~key5_d;

    // BCD increment with saturation at 99
    always_comb begin
        units_sum = {1'b0, score_q[3:0]} + {1'b0, PTS};
        score_bin = 8'(score_q[7:4]) * 8'd10 + 8'(score_q[3:0]);
        score_sat = (score_bin + 8'(PTS)) >= 8'd100;
        if (score_sat)
            score_inc = 8'h99;
        else if (units_sum > 5'd9)
            score_inc = {score_q[7:4] + 4'd1, 4'(units_sum - 5'd10)};
        else
            score_inc = {score_q[7:4], units_sum[3:0]};
    end

`ifdef BONUS_LIFE_EN
    logic bonus_cross;
    assign bonus_cross = (score_q < 8'h50 && score_inc >= 8'h50) ||
                         (score_sat && score_q != 8'h99);
`endif

    always_comb begin
        state_next     = state_q;
        lives_next     = lives_q;
        score_next     = score_q;
        frame_cnt_next = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (key5_rise)
                    state_next = S_SERVE;
            end
            S_SERVE: begin
                if (startOfFrame)
                    state_next = S_PLAY;
            end
            S_PLAY: begin
                if (startOfFrame) begin
                    if (lost_flag) begin
                        state_next     = S_LOST;
                        frame_cnt_next = 8'd0;
                        if (lives_q != 3'd0)
                            lives_next = lives_q - 3'd1;
                    end else if (flip_flag && !prev_flip) begin
                        score_next = score_inc;
`ifdef BONUS_LIFE_EN
                        if (bonus_cross && lives_q != 3'd7)
                            lives_next = lives_q + 3'd1;
`endif
                    end
                end
            end
            S_LOST: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == LAST_FRAME)
                        state_next = (lives_q == 3'd0) ? S_OVER : S_SERVE;
                    else
                        frame_cnt_next = frame_cnt_q + 8'd1;
                end
            end
            S_OVER: begin
                if (key5_rise) begin
                    state_next = S_IDLE;
                    lives_next = LIVES_RST;
                    score_next = 8'h00;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            lives_q     <= LIVES_RST;
            score_q     <= 8'h00;
            frame_cnt_q <= 8'd0;
            key5_d      <= 1'b0;
        end else begin
            state_q     <= state_next;
            lives_q     <= lives_next;
            score_q     <= score_next;
            frame_cnt_q <= frame_cnt_next;
            key5_d      <= key5IsPressed;
        end
    end

    // A collision on the frame-start cycle belongs to the new frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flip_flag <= 1'b0;
            lost_flag <= 1'b0;
            prev_flip <= 1'b0;
        end else if (state_q != S_PLAY) begin
            flip_flag <= 1'b0;
            lost_flag <= 1'b0;
            prev_flip <= 1'b0;
        end else if (startOfFrame) begin
            prev_flip <= flip_flag;
            flip_flag <= collisionSmileyFlipper;
            lost_flag <= collisionSmileyBottom;
        end else begin
            flip_flag <= flip_flag | collisionSmileyFlipper;
            lost_flag <= lost_flag | collisionSmileyBottom;
        end
    end

    always_comb begin
        launchBall = 1'b0;
        freezeBall = 1'b1;
        gameOver   = 1'b0;
        case (state_q)
            S_SERVE: begin
                launchBall = 1'b1;
                freezeBall = 1'b0;
            end
            S_PLAY:  freezeBall = 1'b0;
            S_OVER:  gameOver   = 1'b1;
            default: ;
        endcase
    end

    assign lives    = lives_q;
    assign scoreBCD = score_q;
    assign state    = state_q;

endmodule
